// File: rtl/note_sequencer.sv
// Song ROM walker: fetch {tune,beat}, time the note from the decoder's count, insert a gap, advance.
// Outputs are registered from the next state, so they line up with the state; stop aborts to IDLE in one cycle.
module note_sequencer #(
  parameter int ADDR_W     = 6,
  parameter int SONG_LEN   = 32,
  parameter int GAP_CYCLES = 2500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [3:0]        beat,
  input  logic [27:0]       beat_cnt_parameter,
  output logic [3:0]        tune,
  output logic              note_active,
  output logic              note_strobe,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
  localparam logic [27:0]       GAP_LOAD  = 28'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_ARM, S_PLAY, S_GAP, S_ADV, S_END
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [3:0]        beat_q, beat_d;
  logic [3:0]        tune_q, tune_d;
  logic [27:0]       note_cnt_q, note_cnt_d;
  logic [27:0]       gap_cnt_q, gap_cnt_d;
  logic              note_active_q, note_active_d;
  logic              note_strobe_q, note_strobe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    beat_d     = beat_q;
    tune_d     = tune_q;
    note_cnt_d = note_cnt_q;
    gap_cnt_d  = gap_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          rom_addr_d = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        tune_d  = rom_data[7:4];
        beat_d  = rom_data[3:0];
        state_d = (rom_data[3:0] == 4'd0) ? S_END : S_ARM;
      end
      S_ARM: begin
        // A zero count marks an undecodable beat; the entry is skipped silently.
        if (beat_cnt_parameter == 28'd0) begin
          state_d = S_ADV;
        end else begin
          note_cnt_d = beat_cnt_parameter - 28'd1;
          state_d    = S_PLAY;
        end
      end
      S_PLAY: begin
        if (note_cnt_q == 28'd0) begin
          if (GAP_CYCLES == 0) begin
            state_d = S_ADV;
          end else begin
            gap_cnt_d = GAP_LOAD;
            state_d   = S_GAP;
          end
        end else begin
          note_cnt_d = note_cnt_q - 28'd1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == 28'd0) state_d = S_ADV;
        else                    gap_cnt_d = gap_cnt_q - 28'd1;
      end
      S_ADV: begin
        if (rom_addr_q != LAST_ADDR) begin
          rom_addr_d = rom_addr_q + 1'b1;
          state_d    = S_FETCH;
        end else if (loop_en) begin
          rom_addr_d = '0;
          state_d    = S_FETCH;
        end else begin
          state_d = S_END;
        end
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (stop && state_q != S_IDLE) state_d = S_IDLE;

    // Outputs are decoded from the next state so the registered copies coincide with it.
    note_active_d = (state_d == S_PLAY) && (tune_q != 4'd0);
    note_strobe_d = (state_q == S_ARM) && (state_d == S_PLAY);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_END);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rom_addr_q    <= '0;
      beat_q        <= '0;
      tune_q        <= '0;
      note_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      note_active_q <= 1'b0;
      note_strobe_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rom_addr_q    <= rom_addr_d;
      beat_q        <= beat_d;
      tune_q        <= tune_d;
      note_cnt_q    <= note_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      note_active_q <= note_active_d;
      note_strobe_q <= note_strobe_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign beat        = beat_q;
  assign tune        = tune_q;
  assign note_active = note_active_q;
  assign note_strobe = note_strobe_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a song-level model predicts note, done and idle events; a monitor checks them.
module tb_note_sequencer;

  localparam int ADDR_W   = 6;
  localparam int SONG_LEN = 4;
  localparam int GAP      = 4;
  localparam int K_NOTE   = 0;
  localparam int K_DONE   = 1;
  localparam int K_IDLE   = 2;

  typedef struct {
    int kind;
    int t;
    int addr;
    int tune;
    int beat;
    int len;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              loop_en = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data = 8'd0;
  logic [3:0]        beat;
  logic [27:0]       beat_cnt_parameter;
  logic [3:0]        tune;
  logic              note_active;
  logic              note_strobe;
  logic              busy;
  logic              done;

  logic [7:0] rom_mem [SONG_LEN];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  ev_t        exp_q[$];

  note_sequencer #(
    .ADDR_W(ADDR_W), .SONG_LEN(SONG_LEN), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .beat(beat),
    .beat_cnt_parameter(beat_cnt_parameter), .tune(tune),
    .note_active(note_active), .note_strobe(note_strobe), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) rom_data <= rom_mem[rom_addr[1:0]];

  function automatic int beat_len(input int b);
    case (b)
      1:       return 16;
      2:       return 8;
      3:       return 4;
      4:       return 2;
      5:       return 1;
      default: return 0;
    endcase
  endfunction

  assign beat_cnt_parameter = 28'(beat_len(int'(beat)));

  function automatic void push(input int k, input int t, input int a, input int tu,
                               input int b, input int l);
    ev_t e;
    e.kind = k; e.t = t; e.addr = a; e.tune = tu; e.beat = b; e.len = l;
    exp_q.push_back(e);
  endfunction

  // Song-level reference: t is the cycle the entry's fetch starts; each entry costs
  // fetch+latch+arm (3), then the note and gap, then one advance cycle.
  task automatic model(input int t0, input int passes, input int cut_t, output int drop_at);
    int t, a, pass, ta, ts, b, tu, l;
    t = t0; a = 0; pass = 1; drop_at = 0;
    for (int guard = 0; guard < 64; guard++) begin
      tu = int'(rom_mem[a][7:4]);
      b  = int'(rom_mem[a][3:0]);
      l  = beat_len(b);
      if (b == 0) begin
        push(K_DONE, t + 2, 0, 0, 0, 0);
        push(K_IDLE, t + 3, 0, 0, 0, 0);
        return;
      end
      if (l == 0) begin
        ta = t + 3;
      end else begin
        ts = t + 3;
        if (cut_t > ts && cut_t <= ts + l) begin
          push(K_NOTE, ts, a, tu, b, (tu != 0) ? cut_t - ts : 0);
          push(K_IDLE, cut_t, 0, 0, 0, 0);
          return;
        end
        push(K_NOTE, ts, a, tu, b, (tu != 0) ? l : 0);
        ta = ts + l + GAP;
      end
      if (a != SONG_LEN - 1) begin
        a++;
        t = ta + 1;
      end else if (pass < passes) begin
        pass++;
        a = 0;
        t = ta + 1;
        if (pass == passes) drop_at = t;
      end else begin
        push(K_DONE, ta + 1, 0, 0, 0, 0);
        push(K_IDLE, ta + 2, 0, 0, 0, 0);
        return;
      end
    end
  endtask

  function automatic void observe(input int k, input int t, input int a, input int tu,
                                  input int b, input int l);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event got kind=%0d t=%0d addr=%0d tune=%0d beat=%0d len=%0d, none required",
               k, t, a, tu, b, l);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || e.t != t ||
        (k == K_NOTE && (e.addr != a || e.tune != tu || e.beat != b || e.len != l))) begin
      failures++;
      $display("FAIL event got kind=%0d t=%0d addr=%0d tune=%0d beat=%0d len=%0d, required kind=%0d t=%0d addr=%0d tune=%0d beat=%0d len=%0d",
               k, t, a, tu, b, l, e.kind, e.t, e.addr, e.tune, e.beat, e.len);
    end
  endfunction

  // Monitor: turns pin activity into events, sampled on the falling edge.
  bit   in_note = 1'b0;
  int   n_t, n_a, n_tu, n_b, n_len;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    if (in_note) begin
      if (note_active) n_len++;
      else begin
        in_note = 1'b0;
        observe(K_NOTE, n_t, n_a, n_tu, n_b, n_len);
      end
    end
    if (note_strobe) begin
      n_t = cyc; n_a = int'(rom_addr); n_tu = int'(tune); n_b = int'(beat); n_len = 0;
      if (note_active) begin
        in_note = 1'b1;
        n_len   = 1;
      end else begin
        observe(K_NOTE, n_t, n_a, n_tu, n_b, 0);
      end
    end
    if (done) observe(K_DONE, cyc, 0, 0, 0, 0);
    if (prev_busy && !busy) observe(K_IDLE, cyc, 0, 0, 0, 0);
    prev_busy = busy;
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rom(input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
    rom_mem[0] = e0; rom_mem[1] = e1; rom_mem[2] = e2; rom_mem[3] = e3;
  endtask

  task automatic run_song(input int passes, input int stop_off, input int rst_off);
    int t0, cut_t, drop_at;
    @(posedge clk); #1;
    loop_en = (passes > 1);
    start   = 1'b1;
    t0      = cyc + 1;
    cut_t   = (stop_off > 0) ? t0 + 3 + stop_off : (rst_off > 0) ? t0 + 3 + rst_off : 0;
    model(t0, passes, cut_t, drop_at);
    @(posedge clk); #1;
    start = 1'b0;
    if (stop_off > 0) begin
      // A start pulse mid-note must be ignored.
      wait_cyc(t0 + 4);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_cyc(cut_t - 1);
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
    end
    if (rst_off > 0) begin
      wait_cyc(cut_t);
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({rom_addr, beat, tune, note_active, note_strobe, busy, done} != '0) begin
        failures++;
        $display("FAIL async_reset_clear got addr=%0d beat=%0d tune=%0d act=%b stb=%b busy=%b done=%b, required all 0",
                 rom_addr, beat, tune, note_active, note_strobe, busy, done);
      end
      @(posedge clk); #1;
      rst = 1'b0;
    end
    if (drop_at != 0) begin
      wait_cyc(drop_at);
      loop_en = 1'b0;
    end
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    loop_en = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_song busy=%b required=0", busy);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    set_rom(8'h13, 8'h24, 8'h35, 8'h11);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rom_addr, beat, tune, note_active, note_strobe, busy, done} != '0) begin
      failures++;
      $display("FAIL reset_state got addr=%0d beat=%0d tune=%0d act=%b stb=%b busy=%b done=%b, required all 0",
               rom_addr, beat, tune, note_active, note_strobe, busy, done);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);

    set_rom(8'h13, 8'h24, 8'h35, 8'h11); run_song(1, 0, 0);   // plain song
    set_rom(8'h13, 8'h00, 8'h35, 8'h11); run_song(1, 0, 0);   // terminator at address 1
    set_rom(8'h13, 8'h29, 8'h35, 8'h11); run_song(1, 0, 0);   // illegal beat skipped
    set_rom(8'h13, 8'h24, 8'h35, 8'h11); run_song(3, 0, 0);   // looping, then release
    set_rom(8'h21, 8'h24, 8'h35, 8'h11); run_song(1, 8, 0);   // stop mid-note
    set_rom(8'h03, 8'h24, 8'h35, 8'h11); run_song(1, 0, 0);   // rest entry
    set_rom(8'h21, 8'h24, 8'h35, 8'h11); run_song(1, 0, 6);   // reset mid-note

    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < SONG_LEN; i++) begin
        rom_mem[i][7:4] = 4'($urandom_range(0, 15));
        rom_mem[i][3:0] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                       : 4'($urandom_range(1, 5));
      end
      run_song(int'($urandom_range(1, 2)), 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
